// File: rtl/rr_handshake_arbiter.sv
// N-way round-robin arbiter relaying one granted four-phase handshake onto a shared
// downstream request/acknowledge channel, with input synchronizers and a sticky error flag.
module rr_handshake_arbiter #(
    parameter int N           = 4,
    parameter int IDW         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   R,
    output logic [N-1:0]   A,
    output logic           R_OUT,
    input  logic           A_IN,
    output logic [IDW-1:0] GRANT_ID,
    output logic           BUSY,
    output logic           ERR
);

    typedef enum logic [1:0] {IDLE, FWD, HOLD, RTZ} state_t;

    logic [N:0]   sync_in;
    logic [N:0]   sync_out;
    logic [N-1:0] rs;
    logic         as_s;

    assign sync_in = {A_IN, R};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_out = sync_in;
        end else begin : g_sync
            logic [N:0] sync_q [SYNC_STAGES];
            logic [N:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = sync_in;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_d[s] = sync_q[s-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_d[s];
                    end
                end
            end

            assign sync_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rs   = sync_out[N-1:0];
    assign as_s = sync_out[N];

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic           r_out_q, r_out_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW:0]   idx;
    logic           owner_req;

    // First pending request at or after the pointer, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N)) begin
                idx = idx - (IDW+1)'(N);
            end
            if (!found && rs[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    assign owner_req = rs[gid_q];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        r_out_d = r_out_q;
        gid_d   = gid_q;
        busy_d  = busy_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (as_s) begin
                    err_d = 1'b1;
                end
                if (found) begin
                    gid_d   = pick;
                    busy_d  = 1'b1;
                    r_out_d = 1'b1;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (!owner_req) begin
                    err_d = 1'b1;
                end
                if (as_s) begin
                    a_d     = N'(1) << gid_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A dropped ack is flagged but the channel keeps waiting for it.
                if (!as_s) begin
                    err_d = 1'b1;
                end else if (!owner_req) begin
                    r_out_d = 1'b0;
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (!as_s) begin
                    a_d     = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (gid_q == IDW'(N-1)) ? '0 : gid_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            r_out_q <= 1'b0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            r_out_q <= r_out_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign A        = a_q;
    assign R_OUT    = r_out_q;
    assign GRANT_ID = gid_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed plus randomized bench for rr_handshake_arbiter; grants are predicted from the
// request mask the synchronizers delivered and a round-robin pointer kept by the bench.
module tb_rr_handshake_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int SYNC = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   R;
    logic [N-1:0]   A;
    logic           R_OUT;
    logic           A_IN;
    logic [IDW-1:0] GRANT_ID;
    logic           BUSY;
    logic           ERR;

    rr_handshake_arbiter #(.N(N), .IDW(IDW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .R(R), .A(A), .R_OUT(R_OUT), .A_IN(A_IN),
        .GRANT_ID(GRANT_ID), .BUSY(BUSY), .ERR(ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [N-1:0] hist [3];
    logic [N-1:0] prev_a = '0;
    logic         prev_busy = 1'b0;
    logic         prev_rout = 1'b0;
    int           model_ptr = 0;
    int           cur_owner = 0;
    int           done_cnt = 0;
    int           grant_log [$];

    bit resp_en = 1'b1;
    int resp_delay = 2;
    int resp_cnt = 0;
    bit wd_en = 1'b1;

    int t_req, t_rout_rise, t_ain_rise, t_ain_fall, t_a_rise, t_a_fall;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting index at or after ptr, wrapping.
    function automatic int expGrant(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] r_val);
        R = r_val;
        t_req = cyc;
    endtask

    task automatic clearStamps();
        t_rout_rise = -100; t_ain_rise = -100; t_ain_fall = -100;
        t_a_rise = -100;    t_a_fall = -100;
    endtask

    task automatic tick();
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = R;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            checkOutput("a_onehot", 32'($countones(A) <= 1), 32'd1);
            if (A != '0) checkOutput("a_owner", 32'(A), BUSY ? (32'd1 << GRANT_ID) : 32'd0);
            if (A !== prev_a) checkOutput("a_change_agree", 32'(R_OUT), 32'(A_IN));
            if (BUSY && !prev_busy) begin
                cur_owner = expGrant(hist[2], model_ptr);
                checkOutput("grant", 32'(GRANT_ID), 32'(cur_owner));
                checkOutput("rout_with_grant", 32'(R_OUT), 32'd1);
                grant_log.push_back(int'(GRANT_ID));
            end
            if (!BUSY && prev_busy) begin
                checkOutput("gid_hold", 32'(GRANT_ID), 32'(cur_owner));
                checkOutput("a_clear_at_done", 32'(A), 32'd0);
                model_ptr = (cur_owner + 1) % N;
                done_cnt++;
            end
            if (R_OUT && !prev_rout) t_rout_rise = cyc;
            if (A != '0 && prev_a == '0) t_a_rise = cyc;
            if (A == '0 && prev_a != '0) t_a_fall = cyc;
        end
        prev_a = A;
        prev_busy = BUSY;
        prev_rout = R_OUT;
        if (!rst) begin
            if (resp_en && R_OUT !== A_IN) begin
                resp_cnt++;
                if (resp_cnt >= resp_delay) begin
                    A_IN = R_OUT;
                    if (A_IN) t_ain_rise = cyc; else t_ain_fall = cyc;
                    resp_cnt = 0;
                end
            end else begin
                resp_cnt = 0;
            end
            if (wd_en) begin
                for (int i = 0; i < N; i++) if (A[i] && R[i]) R[i] = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        R = '0;
        A_IN = 1'b0;
        resp_cnt = 0;
        repeat (3) tick();
        rst = 1'b0;
        model_ptr = 0;
        tick();
    endtask

    task automatic waitDone(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
        checkOutput(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin
        int start;
        rst = 1'b1; R = '0; A_IN = 1'b0;
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        clearStamps();

        doReset();
        checkOutput("rst_a", 32'(A), 32'd0);
        checkOutput("rst_rout", 32'(R_OUT), 32'd0);
        checkOutput("rst_gid", 32'(GRANT_ID), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_err", 32'(ERR), 32'd0);

        // Single request on channel 0
        resp_en = 1; resp_delay = 4; wd_en = 1; clearStamps();
        applyStimulus(4'b0001);
        for (int i = 0; i < 10 && !R_OUT; i++) tick();
        checkOutput("t1_rout_latency", 32'(cyc - t_req), 32'd3);
        checkOutput("t1_gid", 32'(GRANT_ID), 32'd0);
        checkOutput("t1_busy", 32'(BUSY), 32'd1);
        for (int i = 0; i < 40 && A[0] !== 1'b1; i++) tick();
        checkOutput("t1_a_latency", 32'(t_a_rise - t_ain_rise), 32'd3);
        for (int i = 0; i < 60 && BUSY; i++) tick();
        checkOutput("t1_ain_low_at_afall", 32'(A_IN), 32'd0);
        checkOutput("t1_afall_latency", 32'(t_a_fall - t_ain_fall), 32'd3);
        grant_log.delete();
        start = done_cnt;
        applyStimulus(4'b0011);
        waitDone(start + 2, 200, "t1_ptr_done");
        checkOutput("t1_ptr_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        checkOutput("t1_ptr_second", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd0);

        // All four request together
        doReset(); resp_delay = 2; grant_log.delete(); start = done_cnt;
        applyStimulus(4'b1111);
        waitDone(start + 4, 400, "t2_done");
        for (int i = 0; i < N; i++)
            checkOutput("t2_order", 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(i));

        // Wrap after a grant to 3
        grant_log.delete(); start = done_cnt;
        applyStimulus(4'b1001);
        waitDone(start + 2, 200, "t3_done");
        checkOutput("t3_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
        checkOutput("t3_second", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd3);

        // Slow resource, channel 2 arrives during owner 1
        resp_delay = 20; grant_log.delete(); start = done_cnt;
        applyStimulus(4'b0010);
        for (int i = 0; i < 20 && !BUSY; i++) tick();
        repeat (5) tick();
        applyStimulus(R | 4'b0100);
        repeat (10) tick();
        checkOutput("t4_a2_wait", 32'(A[2]), 32'd0);
        checkOutput("t4_owner1", 32'(GRANT_ID), 32'd1);
        waitDone(start + 2, 400, "t4_done");
        checkOutput("t4_next", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd2);
        resp_delay = 2;

        // Stray ack in IDLE
        doReset(); resp_en = 0;
        A_IN = 1'b1;
        repeat (4) tick();
        checkOutput("stray_err", 32'(ERR), 32'd1);
        A_IN = 1'b0; resp_en = 1;

        // Withdrawal before ack
        doReset(); wd_en = 0; resp_delay = 8; start = done_cnt;
        applyStimulus(4'b0001);
        for (int i = 0; i < 10 && !R_OUT; i++) tick();
        tick();
        checkOutput("wd_no_err_yet", 32'(ERR), 32'd0);
        applyStimulus(4'b0000);
        waitDone(start + 1, 100, "wd_done");
        checkOutput("wd_err", 32'(ERR), 32'd1);
        checkOutput("wd_rout", 32'(R_OUT), 32'd0);
        repeat (5) tick();
        checkOutput("wd_err_sticky", 32'(ERR), 32'd1);

        // Async reset in HOLD
        resp_delay = 2;
        applyStimulus(4'b0001);
        for (int i = 0; i < 30 && A[0] !== 1'b1; i++) tick();
        repeat (2) tick();
        checkOutput("hold_reached", 32'(A), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_a", 32'(A), 32'd0);
        checkOutput("arst_rout", 32'(R_OUT), 32'd0);
        checkOutput("arst_busy", 32'(BUSY), 32'd0);
        checkOutput("arst_err", 32'(ERR), 32'd0);
        doReset(); wd_en = 1; grant_log.delete(); start = done_cnt;
        applyStimulus(4'b0110);
        waitDone(start + 2, 200, "arst_done");
        checkOutput("arst_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);

        // Randomized traffic against the round-robin model
        for (int n = 0; n < 1500; n++) begin
            resp_delay = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) begin
                int ch;
                ch = $urandom_range(0, N - 1);
                if (!R[ch] && !A[ch]) R[ch] = 1'b1;
            end
            tick();
        end
        for (int i = 0; i < 500 && (R != '0 || BUSY); i++) tick();
        checkOutput("rand_drain", {30'd0, R == '0, BUSY}, 32'd2);
        checkOutput("rand_err", 32'(ERR), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_handshake_arbiter.md
Name: rr_handshake_arbiter

Overview:
- Clocked N-way round-robin arbiter that shares one downstream four-phase (return-to-zero) request/acknowledge channel among N upstream four-phase requesters.
- Sits between self-timed producers (Mutex/muller_c style channels) and a single shared resource channel.
- A granted requester's handshake is relayed end-to-end; the grant is released only after the full return-to-zero of both sides.
- Synchronizes asynchronous request/ack inputs internally.

Parameters:
- N, 4, number of requesters (2..16).
- IDW, 2, width of GRANT_ID; must satisfy 2^IDW >= N.
- SYNC_STAGES, 2, flip-flop synchronizer depth on every R[i] and on A_IN (0 = inputs already synchronous, no synchronizer).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- R  input  N  upstream requests, one four-phase channel per bit.
- A  output  N  upstream acknowledges, one-hot or zero.
- R_OUT  output  1  request to shared resource.
- A_IN  input  1  acknowledge from shared resource.
- GRANT_ID  output  IDW  index of current owner; valid while BUSY=1.
- BUSY  output  1  high from grant until the owner's A falls.
- ERR  output  1  sticky protocol-violation flag, cleared only by rst.

Behaviour:
- All outputs registered. In the rules below, Rs and As denote the post-synchronizer values of R and A_IN.
- Reset (async assert, sync-safe deassert): state IDLE, A=0, R_OUT=0, GRANT_ID=0, BUSY=0, ERR=0, round-robin pointer PTR=0.
- FSM states:
  - IDLE:
    - If any Rs bit is set, pick the first set bit searching PTR, PTR+1, ... wrapping modulo N.
    - Next edge: GRANT_ID=g, BUSY=1, R_OUT=1, go to FWD.
    - Grant decision is one cycle after the request is visible in Rs.
  - FWD: hold R_OUT=1. When As=1, next edge A[g]=1 and go to HOLD.
  - HOLD: hold A[g]=1, R_OUT=1. When Rs[g]=0, next edge R_OUT=0 and go to RTZ.
  - RTZ: hold A[g]=1, R_OUT=0. When As=0, next edge A[g]=0, BUSY=0, PTR=(g+1) mod N, and go to IDLE.
- Handshake ordering guaranteed (mirrors a C-element join):
  - R[g] rise -> R_OUT rise -> A_IN rise -> A[g] rise -> R[g] fall -> R_OUT fall -> A_IN fall -> A[g] fall.
  - A[g] never changes while R_OUT and A_IN disagree.
- Mutual exclusion: at most one A bit high at any time. A[i]=1 only when i==GRANT_ID and BUSY=1.
- Non-granted requests stay pending, are not acknowledged and are not lost; they are arbitered in the next IDLE.
- Fairness: a continuously requesting channel is granted within N transactions.
- Simultaneous requests in IDLE: lowest index at or after PTR wins.
- No back-to-back skip: IDLE always lasts at least one cycle between transactions.
- Protocol violations:
  - Rs[g] falls while in FWD (withdrawal before ack): set ERR=1. The transaction still completes; HOLD exits immediately once As=1 is seen.
  - As falls while in HOLD: set ERR=1; no state change.
  - As=1 while in IDLE: set ERR=1.
- Reset mid-transaction: all outputs drop asynchronously to reset values. Upstream/downstream must return to zero before new requests; this is not checked.
- GRANT_ID holds its last value after BUSY falls.

Test Plan:
- Single request, N=4, SYNC_STAGES=2:
  - Stimulus: R=0001, resource acks 3 cycles after R_OUT.
  - Required: R_OUT rises 3 cycles after R[0] (2 sync + 1), GRANT_ID=0.
  - Required: A[0] rises 3 cycles after A_IN. A[0] falls only after A_IN returns to 0. PTR becomes 1.
- Simultaneous requests R=1111 held until acked, each withdrawn after its ack:
  - Required grant order 0,1,2,3, with A one-hot every cycle and an IDLE cycle between grants.
- Round-robin wrap: after a grant to 3, assert R=1001.
  - Required: next grant is 0, then 3.
- Slow resource: A_IN delayed 20 cycles, while R[2] asserts mid-transaction of owner 1.
  - Required: A[2] stays 0 until owner 1 fully completes; then GRANT_ID=2.
- Withdrawal violation: drop R[0] while in FWD.
  - Required: ERR=1 sticky, and the transaction completes through IDLE.
  - Stray A_IN in IDLE on a fresh run also sets ERR.
- Async reset asserted while in HOLD:
  - Required: A, R_OUT, BUSY, ERR immediately 0 with no clock edge needed. PTR=0; the next grant with R=0110 goes to 1.
